con_poller: RTL and testbench

Serial gamepad poller sitting directly upstream of the input subsystem's `con_state` bus, which feeds the HPS input PIO. It periodically latches a 16-button shift-register controller (SNES-style latch/clock/data) on GPIO, shifts out all 16 buttons, synchronizes and inverts the active-low data, and presents a stable, registered 16-bit button word plus a one-cycle update strobe. It runs on the 50 MHz fabric clock and the combined PLL-locked system reset.

---
 rtl/con_poller.sv | 166 ++++++++++++++++
 tb/tb_con_poller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/con_poller.sv
// con_poller: periodic poller for a 16-button SNES-style shift-register gamepad.
//
// Each poll pulses the latch, clocks out 16 bits, inverts the active-low serial
// data and publishes the button word on con_state with a one-cycle con_valid strobe.
//
// Handshake: con_valid is a push-only strobe with no ready. It is high for
// exactly one cycle per completed poll, and con_state is valid in that cycle
// and holds its value until the next strobe. There is no back-pressure.
//
// Ports:
//   clk        in   fabric clock (single domain)
//   rst_n      in   synchronous active-low reset
//   en         in   poll enable, sampled only on a poll tick
//   con_latch  out  controller latch, active-high
//   con_clk    out  controller shift clock, idles high
//   con_data   in   controller serial data, active-low, asynchronous
//   con_state  out  button word, 1 = pressed, bit i = i-th bit shifted out
//   con_valid  out  one-cycle pulse when con_state updates
//   dbg_state  out  current FSM state (0 IDLE, 1 LATCH, 2 CLK_LO, 3 CLK_HI, 4 DONE)
module con_poller #(
  parameter int POLL_PERIOD = 833_333,
  parameter int HALF_BIT    = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        con_latch,
  output logic        con_clk,
  input  logic        con_data,
  output logic [15:0] con_state,
  output logic        con_valid,
  output logic [2:0]  dbg_state
);

  localparam int PCW = $clog2(POLL_PERIOD);
  localparam int PHW = $clog2(2 * HALF_BIT);

  localparam logic [PCW-1:0] TICK_AT   = PCW'(POLL_PERIOD - 1);
  localparam logic [PHW-1:0] LATCH_END = PHW'(2 * HALF_BIT - 1);
  localparam logic [PHW-1:0] HALF_END  = PHW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_CLK_LO = 3'd2,
    S_CLK_HI = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         r_state;
  logic [PCW-1:0] r_poll_cnt;
  logic [PHW-1:0] r_phase;
  logic [3:0]     r_idx;
  logic [15:0]    r_shift;
  logic           r_sync1;
  logic           r_sync2;
  logic           w_tick;

  assign w_tick    = (r_poll_cnt == TICK_AT);
  assign dbg_state = r_state;

  // Free-running poll period counter; the tick is its last count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_poll_cnt <= '0;
    end else if (w_tick) begin
      r_poll_cnt <= '0;
    end else begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous controller data line. Resets to
  // the released (idle-high) level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= con_data;
      r_sync2 <= r_sync1;
    end
  end

  // Poll sequencer. All outputs are registered and set on the transition into
  // the state that owns them, so each output level lines up with its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      con_latch <= 1'b0;
      con_clk   <= 1'b1;
      con_state <= '0;
      con_valid <= 1'b0;
    end else begin
      con_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_phase <= '0;
          // A tick with en low is simply dropped.
          if (w_tick && en) begin
            r_state   <= S_LATCH;
            con_latch <= 1'b1;
          end
        end

        S_LATCH: begin
          if (r_phase == LATCH_END) begin
            r_state   <= S_CLK_LO;
            r_phase   <= '0;
            r_idx     <= '0;
            con_latch <= 1'b0;
            con_clk   <= 1'b0;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        S_CLK_LO: begin
          if (r_phase == HALF_END) begin
            // Sample at the end of the low phase so the data has settled for
            // a full half-bit plus the synchronizer delay.
            r_shift[r_idx] <= ~r_sync2;
            r_state        <= S_CLK_HI;
            r_phase        <= '0;
            con_clk        <= 1'b1;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        S_CLK_HI: begin
          if (r_phase == HALF_END) begin
            r_phase <= '0;
            if (r_idx == 4'd15) begin
              // Publish on entry to DONE so the new word and the strobe are
              // both visible during the DONE cycle itself.
              r_state   <= S_DONE;
              con_state <= r_shift;
              con_valid <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_CLK_LO;
              con_clk <= 1'b0;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_phase <= '0;
        end

        default: begin
          r_state <= S_IDLE;
          r_phase <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_con_poller.sv
// tb_con_poller: self-checking bench for con_poller with POLL_PERIOD=200 and
// HALF_BIT=4. A behavioural gamepad model loads an active-low word while the
// latch is high and shifts on each con_clk rise (optionally skewed 0-2 cycles).
// Expected updates are queued as {cycle, word}; a monitor pops and compares
// on every con_valid. The cycle number counts from the last reset edge.
module tb_con_poller;

  localparam int PP = 200;
  localparam int HB = 4;
  localparam int W  = 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        con_latch;
  logic        con_clk;
  logic        con_data;
  logic [15:0] con_state;
  logic        con_valid;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  con_poller #(.POLL_PERIOD(PP), .HALF_BIT(HB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .con_latch (con_latch),
    .con_clk   (con_clk),
    .con_data  (con_data),
    .con_state (con_state),
    .con_valid (con_valid),
    .dbg_state (dbg_state)
  );

  // ---------------- gamepad model ----------------
  logic [15:0] pad_word = 16'hFFFF;
  logic [15:0] pad_sreg = 16'hFFFF;
  logic        pad_clk_d = 1'b1;
  logic [1:0]  pad_pend = 2'd0;
  logic [1:0]  skew_roll = 2'd0;
  logic        skew_en = 1'b0;

  assign con_data = pad_sreg[0];

  always @(posedge clk) begin
    pad_clk_d <= con_clk;
    skew_roll <= skew_en ? 2'($urandom_range(0, 2)) : 2'd0;
    if (con_latch) begin
      pad_sreg <= pad_word;
      pad_pend <= 2'd0;
    end else if (con_clk && !pad_clk_d) begin
      if (skew_roll == 2'd0) pad_sreg <= {1'b1, pad_sreg[15:1]};
      else                   pad_pend <= skew_roll;
    end else if (pad_pend != 2'd0) begin
      if (pad_pend == 2'd1) pad_sreg <= {1'b1, pad_sreg[15:1]};
      pad_pend <= pad_pend - 2'd1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && con_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got con_valid=1 state=0x%0h at cycle %0d, want no update", con_state, cyc);
      end else begin
        exp_e = exp_q.pop_front();
        check("valid_cycle", 32'(cyc), 32'(exp_e[31:16]));
        check("con_state", 32'(con_state), 32'(exp_e[15:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_cyc: got cycle %0d, want %0d", cyc, n);
    end
  endtask

  task automatic push_exp(input int at_cycle, input logic [15:0] pad);
    exp_q.push_back({16'(at_cycle), ~pad});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int falls;
    int lows;
    logic prev_clk;
    logic exp_latch;
    logic exp_clk;
    logic [15:0] w;

    // Reset / idle with en low: nothing may happen across two discarded ticks.
    en = 1'b0;
    pad_word = 16'h5A3C;
    do_reset(5);
    check("rst_latch", 32'(con_latch), 32'd0);
    check("rst_clk", 32'(con_clk), 32'd1);
    check("rst_state", 32'(con_state), 32'd0);
    check("rst_valid", 32'(con_valid), 32'd0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      check("idle_latch", 32'(con_latch), 32'd0);
      check("idle_clk", 32'(con_clk), 32'd1);
      check("idle_state", 32'(con_state), 32'd0);
      check("idle_fsm", 32'(dbg_state), 32'd0);
    end

    // Single poll: word 5A3C active-low -> A5C3 pressed, valid at cycle 336.
    en = 1'b1;
    do_reset(5);
    push_exp(336, 16'h5A3C);
    falls = 0;
    lows = 0;
    prev_clk = 1'b1;
    for (int c = 1; c <= 340; c++) begin
      @(negedge clk);
      if (cyc >= 199) begin
        exp_latch = (cyc >= 200 && cyc <= 207);
        exp_clk   = !(cyc >= 208 && cyc < 336 && ((cyc - 208) % 8) < 4);
        check("wave_latch", 32'(con_latch), 32'(exp_latch));
        check("wave_clk", 32'(con_clk), 32'(exp_clk));
        if (prev_clk && !con_clk) falls++;
        if (!con_clk) lows++;
        prev_clk = con_clk;
      end
    end
    check("clk_falls", 32'(falls), 32'd16);
    check("clk_low_cycles", 32'(lows), 32'd64);

    // Periodic update: all released -> 0 at 536; then 0F0F -> F0F0 at 736.
    pad_word = 16'hFFFF;
    push_exp(536, 16'hFFFF);
    wait_cyc(550);
    pad_word = 16'h0F0F;
    push_exp(736, 16'h0F0F);

    // Enable gating: ticks at 799 and 999 are dropped, state holds F0F0.
    wait_cyc(740);
    en = 1'b0;
    pad_word = 16'h1234;
    for (int c = 741; c <= 1100; c++) begin
      @(negedge clk);
      check("gate_latch", 32'(con_latch), 32'd0);
      check("gate_state", 32'(con_state), 32'hF0F0);
    end
    en = 1'b1;
    push_exp(1336, 16'h1234);
    wait_cyc(1199);
    check("resume_latch_pre", 32'(con_latch), 32'd0);
    wait_cyc(1200);
    check("resume_latch", 32'(con_latch), 32'd1);

    // Reset mid-shift: poll at 1399, bit 7 low phase spans 1464..1467.
    wait_cyc(1465);
    check("mid_clk_low", 32'(con_clk), 32'd0);
    check("mid_fsm", 32'(dbg_state), 32'd2);
    check("mid_state_held", 32'(con_state), 32'hEDCB);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_clk", 32'(con_clk), 32'd1);
    check("mr_latch", 32'(con_latch), 32'd0);
    check("mr_state", 32'(con_state), 32'd0);
    check("mr_valid", 32'(con_valid), 32'd0);
    rst_n = 1'b1;
    pad_word = 16'hC3A5;
    push_exp(336, 16'hC3A5);
    wait_cyc(199);
    check("mr_next_pre", 32'(con_latch), 32'd0);
    wait_cyc(200);
    check("mr_next_latch", 32'(con_latch), 32'd1);

    // Skewed data edges over 50 transactions with random words.
    wait_cyc(340);
    skew_en = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      wait_cyc(PP * k + 150);
      w = 16'($urandom_range(0, 65535));
      pad_word = w;
      push_exp(PP * k + 336, w);
    end
    wait_cyc(PP * 50 + 340);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

endmodule
